// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, evaluation result out, for the expr_eval block.
interface expr_eval_if #(parameter int W = 16);
    logic [7:0]   in;
    logic         in_valid;
    logic         in_ready;
    logic         partial_ok;
    logic         done;
    logic         ok;
    logic [W-1:0] result;
    modport master (output in, in_valid, input in_ready, partial_ok, done, ok, result);
    modport slave  (input in, in_valid, output in_ready, partial_ok, done, ok, result);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator of single-digit +/* expressions terminated by '='.
// Define EXPR_EVAL_SUB_EN to accept '-' as an additive operator.
module expr_eval #(parameter int W = 16) (
    input logic       clk,
    input logic       clr,
    expr_eval_if.slave bus
);
    typedef enum logic [2:0] {IDLE, NUM, OP, ERR, DONE} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d, term_q, term_d, result_q, result_d;
    logic         pend_mul_q, pend_mul_d, done_q, done_d, ok_q, ok_d;
    logic         fire, is_dig, is_add, is_mul, is_eq, is_nul, is_sub, neg_q;
    logic [W-1:0] dig, dig_s, prod;
    assign fire   = bus.in_valid && bus.in_ready;
    assign is_dig = bus.in >= 8'h30 && bus.in <= 8'h39;
    assign is_add = bus.in == 8'h2b;
    assign is_mul = bus.in == 8'h2a;
    assign is_eq  = bus.in == 8'h3d;
    assign is_nul = bus.in == 8'h00;
    assign dig    = W'(bus.in[3:0]);
    assign dig_s  = neg_q ? -dig : dig;
    assign prod   = W'(term_q * bus.in[3:0]);
`ifdef EXPR_EVAL_SUB_EN
    logic neg_d;
    assign is_sub = bus.in == 8'h2d;
    // The negate flag only matters when OP loads a fresh term.
    always_comb neg_d = (fire && state_q == NUM) ? is_sub : (state_q == DONE ? 1'b0 : neg_q);
    always_ff @(posedge clk or posedge clr)
        if (clr) neg_q <= 1'b0;
        else     neg_q <= neg_d;
`else
    assign is_sub = 1'b0;
    assign neg_q  = 1'b0;
`endif
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        term_d     = term_q;
        pend_mul_d = pend_mul_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        result_d   = result_q;
        if (state_q == DONE) begin
            state_d    = IDLE;
            sum_d      = '0;
            term_d     = '0;
            pend_mul_d = 1'b0;
        end else if (fire) begin
            if (is_eq) begin
                state_d  = DONE;
                done_d   = 1'b1;
                ok_d     = state_q == NUM;
                result_d = state_q == NUM ? sum_q + term_q : '0;
            end else if (state_q == IDLE) begin
                if (is_dig) begin
                    state_d = NUM;
                    term_d  = dig;
                    sum_d   = '0;
                end else if (!is_nul) begin
                    state_d = ERR;
                end
            end else if (state_q == NUM) begin
                if (is_add || is_sub) begin
                    state_d    = OP;
                    sum_d      = sum_q + term_q;
                    pend_mul_d = 1'b0;
                end else if (is_mul) begin
                    state_d    = OP;
                    pend_mul_d = 1'b1;
                end else begin
                    state_d = ERR;
                end
            end else if (state_q == OP) begin
                state_d = is_dig ? NUM : ERR;
                term_d  = is_dig ? (pend_mul_q ? prod : dig_s) : term_q;
            end
        end
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            term_q     <= '0;
            pend_mul_q <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            term_q     <= term_d;
            pend_mul_q <= pend_mul_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            result_q   <= result_d;
        end
    end
    assign bus.in_ready   = state_q != DONE;
    assign bus.partial_ok = state_q == NUM;
    assign bus.done       = done_q;
    assign bus.ok         = ok_q;
    assign bus.result     = result_q;
endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming evaluator for single-digit `+`/`*` ASCII expressions. It consumes one character per accepted cycle and sequences a sum/term multiply-accumulate datapath with `*`-before-`+` precedence. On the terminator `=` it reports whether the expression was well-formed, together with its value. It sits behind the expression recognizer in the character-stream path and drives the result bus to downstream logic.

## Interface
- `W`, default 16: width of the sum, term and result datapath. Arithmetic is modulo 2^W.
- `clk`  input  1  clock; all state updates on the rising edge.
- `clr`  input  1  reset, asynchronous, active-high.
- `in`  input  8  ASCII character.
- `in_valid`  input  1  `in` carries a character this cycle.
- `in_ready`  output  1  block accepts a character this cycle. A character is consumed when `in_valid && in_ready`.
- `partial_ok`  output  1  the prefix consumed so far is a complete valid expression (Moore, state NUM only).
- `done`  output  1  one-cycle pulse when an expression is terminated.
- `ok`  output  1  the last terminated expression was valid. Valid when `done` is high; held until the next `done` or `clr`.
- `result`  output  W  value of the last valid expression, or 0 if it was invalid. Held like `ok`.

## Operation
- Character classes:
  - DIG: `"0"`..`"9"`, value = `in - 8'h30`.
  - ADD: `"+"`.
  - MUL: `"*"`.
  - EQ: `"="`.
  - NUL: 8'h00.
  - OTHER: every other code.
- Registers:
  - `sum[W-1:0]`: committed additive terms.
  - `term[W-1:0]`: current product term.
  - `pend_mul`: the last operator was MUL.
- States: IDLE, NUM, OP, ERR, DONE. DONE is a one-cycle report state.
- Transitions apply only on a consumed character.
- IDLE:
  - DIG → NUM with `term` = digit, `sum` = 0.
  - NUL → stay in IDLE.
  - EQ → DONE (error).
  - ADD, MUL, OTHER → ERR.
- NUM:
  - ADD → OP with `sum` = `sum + term`, `pend_mul` = 0.
  - MUL → OP with `pend_mul` = 1.
  - EQ → DONE (valid, value `sum + term`).
  - DIG, NUL, OTHER → ERR.
- OP:
  - DIG → NUM. If `pend_mul`, `term` = `term * digit` truncated to W; otherwise `term` = digit.
  - EQ → DONE (error).
  - Anything else → ERR.
- ERR: EQ → DONE (error). All other characters keep the state in ERR; the block resynchronises only on `=`.
- DONE, on entry edge:
  - Valid termination: `ok` <= 1, `result` <= `sum + term`.
  - Error termination: `ok` <= 0, `result` <= 0.
  - DONE exits unconditionally to IDLE on the next edge and clears `sum`, `term` and `pend_mul`.
- `in_ready` = 1 in every state except DONE.
- `partial_ok` = 1 iff state is NUM.
- Empty expression (`=` from IDLE) is an error.

## Timing
- Reset values:
  - State = IDLE; `sum`, `term`, `pend_mul` = 0.
  - `done` = 0, `ok` = 0, `result` = 0, `partial_ok` = 0, `in_ready` = 1.
- `clr` mid-expression aborts immediately. No `done` is produced for the aborted expression.
- Latency: `done`, `ok` and `result` update on the edge that consumes `=`. All three are registered and visible the following cycle, with `done` high for exactly that cycle.
- `in_ready` is low during the DONE cycle. A character presented then is not consumed and must be held by the source.
- Back-to-back expressions: the first character of the next expression can be consumed 2 cycles after `=` is consumed.
- `in_valid` low: no state or register change. `done` still deasserts after its single cycle.
- The multiply is W×4 combinational, single cycle. Overflow wraps silently and is not an error.

## Configuration
- `EXPR_EVAL_SUB_EN` defined:
  - `"-"` is a legal operator with the same precedence as `+`.
  - In NUM, `"-"` → OP with `sum` = `sum + term`, `pend_mul` = 0, and a negate flag set.
  - The next DIG then loads `term` = −digit (two's complement, W bits).
  - A subsequent MUL multiplies the negated term.
- `EXPR_EVAL_SUB_EN` undefined: `"-"` is OTHER, so it drives the state to ERR, and no negate flag is built.

## Test plan
- "3+4*5=" with `in_valid` held high → `done` pulse with `ok`=1, `result`=23; `partial_ok` high after the 3, the 4 and the 5.
- "2*3*4+1=" → `ok`=1, `result`=25. Then "7=" sent back-to-back, respecting `in_ready` low for one cycle → `ok`=1, `result`=7.
- Malformed inputs:
  - "+3=" → `ok`=0, `result`=0.
  - "34=" → `ok`=0.
  - "=" from IDLE → `ok`=0.
  - "3+=" → `ok`=0.
  - For "+3=", "9=" must then yield `ok`=1, `result`=9.
- With W=8, "9*9*9*9=" → `result`=161 (6561 mod 256), `ok`=1.
- Reset and gaps:
  - Assert `clr` after "5+6" → all outputs 0, no `done`; then "1=" → `result`=1.
  - NUL bytes and `in_valid` gaps in IDLE → no state change.
- With `EXPR_EVAL_SUB_EN`: "5-2*3=" → `result` = 2^W−1 (−1), `ok`=1. Without the macro the same stream → `ok`=0.
